// File: rtl/kawiarka_pkg.sv
// ----------------------------------------------------------------------------
// kawiarka_pkg
// Shared definitions for the coffee-machine brewing controller.
//   stage_t     : 3-bit stage code carried on the controller's `stage` port
//   ST_*        : stage codes used by the preparation FSM
//   stage_time  : maps a stage code to its hold time in clock cycles
// ----------------------------------------------------------------------------
package kawiarka_pkg;

    typedef logic [2:0] stage_t;

    localparam stage_t ST_IDLE = 3'b000;
    localparam stage_t ST_GW   = 3'b001;  // heating
    localparam stage_t ST_MK   = 3'b010;  // grinding
    localparam stage_t ST_SK   = 3'b100;  // dosing
    localparam stage_t ST_ZW   = 3'b110;  // pouring

    // Hold time of a stage; IDLE and unused codes have no timed duration.
    function automatic int unsigned stage_time(
        input stage_t      s,
        input int unsigned t_gw,
        input int unsigned t_mk,
        input int unsigned t_sk,
        input int unsigned t_zw
    );
        case (s)
            ST_GW:   stage_time = t_gw;
            ST_MK:   stage_time = t_mk;
            ST_SK:   stage_time = t_sk;
            ST_ZW:   stage_time = t_zw;
            default: stage_time = 0;
        endcase
    endfunction

endpackage

// File: rtl/arbiter_rr.sv
// ----------------------------------------------------------------------------
// arbiter_rr
// Round-robin arbiter for N_REQ requesters. The pick is combinational; the
// pointer (index of the last served requester) is registered and moves only
// on the `update` strobe, taking the index of the one-hot `grant` input.
// After reset the pointer sits at N_REQ-1, so index 0 has highest priority.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   grant    : one-hot grant currently being served (source of new pointer)
//   update   : load pointer from `grant` on this edge
//   pick     : one-hot winner among `req`, all zero when no request
// ----------------------------------------------------------------------------
module arbiter_rr #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] grant,
    input  logic             update,
    output logic [N_REQ-1:0] pick
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] grant_idx;

    // Search starts one past the last served index and wraps around.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_W'(N_REQ - 1);
        end else if (update) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/sterownik_kawiarki.sv
// ----------------------------------------------------------------------------
// sterownik_kawiarki
// Brewing-cycle controller: round-robin arbitration of N_REQ order sources
// onto one brewing unit, then IDLE -> GW (heat) -> MK (grind) -> SK (dose)
// -> ZW (pour) -> IDLE, each stage held for its T_* cycles.
//   clk, rst          : clock, synchronous active-high reset
//   req               : level requests, held until `done` with own grant bit
//   gnt               : one-hot grant, zero while idle
//   stage             : current stage code (see kawiarka_pkg)
//   busy              : stage != IDLE
//   heat_en .. pour_en: actuator enables, high exactly in GW/MK/SK/ZW
//   done              : one-cycle pulse on the first IDLE cycle after ZW
// Optional build macro KAWIARKA_GORACA_WODA_EN: keeps water hot for T_HOT
// idle cycles after a brew; a grant inside that window skips heating.
// All outputs are registered.
// ----------------------------------------------------------------------------
module sterownik_kawiarki
    import kawiarka_pkg::*;
#(
    parameter int          N_REQ = 4,
    parameter int          CNT_W = 8,
    parameter int unsigned T_GW  = 8,
    parameter int unsigned T_MK  = 4,
    parameter int unsigned T_SK  = 2,
    parameter int unsigned T_ZW  = 6,
    parameter int unsigned T_HOT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output stage_t           stage,
    output logic             busy,
    output logic             heat_en,
    output logic             grind_en,
    output logic             dose_en,
    output logic             pour_en,
    output logic             done
);

    stage_t             stage_q, stage_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   pick;
    logic               done_d;
    logic               update;
    logic               busy_d, heat_d, grind_d, dose_d, pour_d;

`ifdef KAWIARKA_GORACA_WODA_EN
    localparam int HOT_W = $clog2(T_HOT + 1);
    logic [HOT_W-1:0]   hot_q, hot_d;
`endif

    arbiter_rr #(.N_REQ(N_REQ)) u_arbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .grant  (gnt_q),
        .update (update),
        .pick   (pick)
    );

    // State register: stage, timer, grant and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q  <= ST_IDLE;
            timer_q  <= '0;
            gnt_q    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            heat_en  <= 1'b0;
            grind_en <= 1'b0;
            dose_en  <= 1'b0;
            pour_en  <= 1'b0;
`ifdef KAWIARKA_GORACA_WODA_EN
            hot_q    <= '0;
`endif
        end else begin
            stage_q  <= stage_d;
            timer_q  <= timer_d;
            gnt_q    <= gnt_d;
            done     <= done_d;
            busy     <= busy_d;
            heat_en  <= heat_d;
            grind_en <= grind_d;
            dose_en  <= dose_d;
            pour_en  <= pour_d;
`ifdef KAWIARKA_GORACA_WODA_EN
            hot_q    <= hot_d;
`endif
        end
    end

    // Next-state logic. The timer holds "cycles left minus one", so a stage
    // loaded with T-1 lasts exactly T cycles.
    always_comb begin
        stage_d = stage_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        update  = 1'b0;
`ifdef KAWIARKA_GORACA_WODA_EN
        hot_d   = hot_q;
`endif
        case (stage_q)
            ST_IDLE: begin
`ifdef KAWIARKA_GORACA_WODA_EN
                if (hot_q != '0) hot_d = hot_q - 1'b1;
`endif
                if (req != '0) begin
                    gnt_d   = pick;
                    stage_d = ST_GW;
`ifdef KAWIARKA_GORACA_WODA_EN
                    if (hot_q != '0) begin
                        stage_d = ST_MK;
                        hot_d   = '0;
                    end
`endif
                    timer_d = CNT_W'(stage_time(stage_d, T_GW, T_MK, T_SK, T_ZW) - 1);
                end
            end
            ST_GW, ST_MK, ST_SK: begin
                if (timer_q == '0) begin
                    case (stage_q)
                        ST_GW:   stage_d = ST_MK;
                        ST_MK:   stage_d = ST_SK;
                        default: stage_d = ST_ZW;
                    endcase
                    timer_d = CNT_W'(stage_time(stage_d, T_GW, T_MK, T_SK, T_ZW) - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ZW: begin
                if (timer_q == '0) begin
                    stage_d = ST_IDLE;
                    timer_d = '0;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                    update  = 1'b1;  // pointer takes the index being released
`ifdef KAWIARKA_GORACA_WODA_EN
                    hot_d   = HOT_W'(T_HOT);
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                // Unused codes recover to IDLE silently.
                stage_d = ST_IDLE;
                timer_d = '0;
                gnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next stage, registered alongside it.
    always_comb begin
        busy_d  = (stage_d != ST_IDLE);
        heat_d  = (stage_d == ST_GW);
        grind_d = (stage_d == ST_MK);
        dose_d  = (stage_d == ST_SK);
        pour_d  = (stage_d == ST_ZW);
    end

    assign gnt   = gnt_q;
    assign stage = stage_q;

endmodule

// File: tb/tb_sterownik_kawiarki.sv
// ----------------------------------------------------------------------------
// tb_sterownik_kawiarki
// Self-checking bench for sterownik_kawiarki. Expected brews (grant, first
// stage, per-stage cycle counts) go into a scoreboard queue when a request
// is driven and are popped when the DUT raises a grant.
// ----------------------------------------------------------------------------
module tb_sterownik_kawiarki;
    import kawiarka_pkg::*;

    localparam int N    = 4;
    localparam int TGW  = 8;
    localparam int TMK  = 4;
    localparam int TSK  = 2;
    localparam int TZW  = 6;
    localparam int THOT = 16;

    typedef struct {
        logic [N-1:0] gnt;
        logic [2:0]   first;
        int           gw;
        int           mk;
        int           sk;
        int           zw;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    stage_t       stage;
    logic         busy, heat_en, grind_en, dose_en, pour_en, done;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    sterownik_kawiarki #(
        .N_REQ(N), .CNT_W(8), .T_GW(TGW), .T_MK(TMK), .T_SK(TSK),
        .T_ZW(TZW), .T_HOT(THOT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .stage(stage),
        .busy(busy), .heat_en(heat_en), .grind_en(grind_en),
        .dose_en(dose_en), .pour_en(pour_en), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    // Expected brew: full sequence, or skipping heating when water is hot.
    task automatic push_exp(input logic [N-1:0] g, input bit hot);
        exp_t e;
        e.gnt   = g;
        e.first = hot ? ST_MK : ST_GW;
        e.gw    = hot ? 0 : TGW;
        e.mk    = TMK;
        e.sk    = TSK;
        e.zw    = TZW;
        exp_q.push_back(e);
    endtask

    // Waits for a grant, compares it with the scoreboard head and follows
    // the brew to its done pulse. Returns at the negedge where done is seen.
    task automatic observe_brew(input logic [2:0] drop_stage, input bit release_at_done,
                                output int gnt_cyc, output int done_cyc);
        exp_t e;
        int budget, n_gw, n_mk, n_sk, n_zw, en_err;
        gnt_cyc = -1; done_cyc = -1;
        n_gw = 0; n_mk = 0; n_sk = 0; n_zw = 0; en_err = 0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (gnt === '0 && budget < 200);
        n_total++;
        if (gnt === '0) begin
            $display("FAIL grant_timeout: gnt=%b after %0d cycles, want nonzero", gnt, budget);
            return;
        end
        n_pass++;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: unexpected gnt=%b", gnt);
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        gnt_cyc = cyc;
        n_total++;
        if (gnt !== e.gnt) $display("FAIL grant_value: got %b want %b", gnt, e.gnt);
        else n_pass++;
        n_total++;
        if (stage !== e.first) $display("FAIL first_stage: got %b want %b", stage, e.first);
        else n_pass++;
        budget = 0;
        while (done !== 1'b1 && budget < 300) begin
            case (stage)
                ST_GW: n_gw++;
                ST_MK: n_mk++;
                ST_SK: n_sk++;
                ST_ZW: n_zw++;
                default: en_err++;
            endcase
            if (heat_en !== (stage === ST_GW) || grind_en !== (stage === ST_MK) ||
                dose_en !== (stage === ST_SK) || pour_en !== (stage === ST_ZW) ||
                busy !== 1'b1 || gnt !== e.gnt)
                en_err++;
            if (stage === drop_stage) req = req & ~e.gnt;
            @(negedge clk);
            budget++;
        end
        done_cyc = cyc;
        n_total++;
        if (done !== 1'b1) $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, budget);
        else n_pass++;
        n_total++;
        if (n_gw !== e.gw) $display("FAIL gw_len: got %0d want %0d", n_gw, e.gw);
        else n_pass++;
        n_total++;
        if (n_mk !== e.mk) $display("FAIL mk_len: got %0d want %0d", n_mk, e.mk);
        else n_pass++;
        n_total++;
        if (n_sk !== e.sk) $display("FAIL sk_len: got %0d want %0d", n_sk, e.sk);
        else n_pass++;
        n_total++;
        if (n_zw !== e.zw) $display("FAIL zw_len: got %0d want %0d", n_zw, e.zw);
        else n_pass++;
        n_total++;
        if (en_err !== 0) $display("FAIL brew_outputs: %0d bad cycles, want 0", en_err);
        else n_pass++;
        n_total++;
        if ({gnt, stage, busy, heat_en, grind_en, dose_en, pour_en} !== '0)
            $display("FAIL done_cycle_idle: gnt=%b stage=%b busy=%b en=%b%b%b%b, want all 0",
                     gnt, stage, busy, heat_en, grind_en, dose_en, pour_en);
        else n_pass++;
        if (release_at_done) req = req & ~e.gnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({gnt, stage, busy, heat_en, grind_en, dose_en, pour_en, done} !== '0)
            $display("FAIL reset_outputs: gnt=%b stage=%b busy=%b done=%b, want all 0",
                     gnt, stage, busy, done);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (stage !== ST_IDLE || gnt !== '0) $display("FAIL reset_idle: stage=%b gnt=%b, want 000/0000", stage, gnt);
        else n_pass++;
    endtask

    task automatic test_single();
        int g, d;
        req = 4'b0001;
        push_exp(4'b0001, 1'b0);
        observe_brew(ST_IDLE, 1'b1, g, d);
        n_total++;
        if (d - g !== TGW + TMK + TSK + TZW)
            $display("FAIL single_latency: got %0d want %0d", d - g, TGW + TMK + TSK + TZW);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || stage !== ST_IDLE)
            $display("FAIL done_pulse_width: done=%b stage=%b, want 0/000", done, stage);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int g, d, prev;
        logic [N-1:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp(order[i], 1'b0);
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            observe_brew(ST_IDLE, 1'b0, g, d);
            if (i > 0) begin
                n_total++;
                if (g - prev !== TGW + TMK + TSK + TZW + 1)
                    $display("FAIL rr_period: got %0d want %0d", g - prev, TGW + TMK + TSK + TZW + 1);
                else n_pass++;
            end
            prev = g;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_brew();
        int g, d, mk_seen, budget;
        req = 4'b0001;
        mk_seen = 0;
        budget = 0;
        while (mk_seen < 3 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (stage === ST_MK) mk_seen++;
        end
        n_total++;
        if (mk_seen !== 3) $display("FAIL mid_reach_mk: saw %0d MK cycles, want 3", mk_seen);
        else n_pass++;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        n_total++;
        if ({gnt, stage, busy, heat_en, grind_en, dose_en, pour_en, done} !== '0)
            $display("FAIL mid_reset_outputs: gnt=%b stage=%b busy=%b done=%b, want all 0",
                     gnt, stage, busy, done);
        else n_pass++;
        rst = 1'b0;
        // Pointer back at reset value: index 0 wins over index 2.
        req = 4'b0101;
        push_exp(4'b0001, 1'b0);
        observe_brew(ST_IDLE, 1'b1, g, d);
        push_exp(4'b0100, 1'b0);
        observe_brew(ST_IDLE, 1'b1, g, d);
        req = '0;
    endtask

    task automatic test_drop_req();
        int g, d;
        req = 4'b0010;
        push_exp(4'b0010, 1'b0);
        observe_brew(ST_SK, 1'b1, g, d);
        n_total++;
        if (d - g !== TGW + TMK + TSK + TZW)
            $display("FAIL drop_latency: got %0d want %0d", d - g, TGW + TMK + TSK + TZW);
        else n_pass++;
        n_total++;
        if (req !== '0) $display("FAIL drop_req_released: req=%b want 0000", req);
        else n_pass++;
    endtask

    task automatic test_hot_water();
        int g, d;
        // Grant lands 5 edges after the done edge.
        repeat (4) @(negedge clk);
        req = 4'b0001;
`ifdef KAWIARKA_GORACA_WODA_EN
        push_exp(4'b0001, 1'b1);
`else
        push_exp(4'b0001, 1'b0);
`endif
        observe_brew(ST_IDLE, 1'b1, g, d);
        n_total++;
`ifdef KAWIARKA_GORACA_WODA_EN
        if (d - g !== TMK + TSK + TZW) $display("FAIL hot_latency: got %0d want %0d", d - g, TMK + TSK + TZW);
`else
        if (d - g !== TGW + TMK + TSK + TZW) $display("FAIL hot_latency: got %0d want %0d", d - g, TGW + TMK + TSK + TZW);
`endif
        else n_pass++;
        // Grant lands 20 edges after done: the hot window has expired.
        repeat (19) @(negedge clk);
        req = 4'b0001;
        push_exp(4'b0001, 1'b0);
        observe_brew(ST_IDLE, 1'b1, g, d);
    endtask

    task automatic test_illegal_stage();
        repeat (2) @(negedge clk);
        force dut.stage_q = 3'b111;
        #1 release dut.stage_q;
        @(negedge clk);
        n_total++;
        if ({stage, gnt, done, busy, heat_en, grind_en, dose_en, pour_en} !== '0)
            $display("FAIL illegal_recover: stage=%b gnt=%b done=%b busy=%b en=%b%b%b%b, want all 0",
                     stage, gnt, done, busy, heat_en, grind_en, dose_en, pour_en);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reset_mid_brew();
        test_drop_req();
        test_hot_water();
        test_illegal_stage();
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
